// File: rtl/cdf_lane_unpack_fifo_pkg.sv
// Shared constants and lane helpers for the CDF unpack datapath.
// Lane helpers work on max-width containers; callers size-cast results to their own widths.
package cdf_pkg;

  localparam int WORD_W_DEF     = 32;
  localparam int MEM_W_DEF      = 128;
  localparam int NUM_PORTS_DEF  = 2;
  localparam int FIFO_DEPTH_DEF = 4;

  // Containers must cover NUM_PORTS*MEM_W and WORD_W of any instance.
  localparam int FLAT_MAX = 2048;
  localparam int WORD_MAX = 64;

  typedef logic [FLAT_MAX-1:0] flat_t;
  typedef logic [WORD_MAX-1:0] word_t;

  // Word k of a flat vector, w bits per word, zero-extended.
  function automatic word_t lane_word(input flat_t flat, input int k, input int w);
    word_t mask;
    mask = (w >= WORD_MAX) ? '1 : ((word_t'(1) << w) - word_t'(1));
    return word_t'(flat >> (k * w)) & mask;
  endfunction

  // a - b clamped at zero.
  function automatic word_t sat_sub(input word_t a, input word_t b);
    return (a < b) ? '0 : (a - b);
  endfunction

endpackage

// File: rtl/cdf_lane_unpack_fifo_if.sv
// Memory-side and divider-side handshake bundle for cdf_lane_unpack_fifo.
interface cdf_lane_unpack_fifo_if
  import cdf_pkg::*;
#(
  parameter int BEAT_W = NUM_PORTS_DEF * MEM_W_DEF,
  parameter int OUT_W  = NUM_PORTS_DEF * MEM_W_DEF
);
  logic              sc_mem_rd_data_rdy;
  logic [BEAT_W-1:0] sc_mem_rd_data;
  logic              mem_rd_ready;
  logic [OUT_W-1:0]  cdfval_todiv;
  logic              cdfval_valid;
  logic              div_ready;

  modport slave (
    input  sc_mem_rd_data_rdy, sc_mem_rd_data, div_ready,
    output mem_rd_ready, cdfval_todiv, cdfval_valid
  );

  modport master (
    output sc_mem_rd_data_rdy, sc_mem_rd_data, div_ready,
    input  mem_rd_ready, cdfval_todiv, cdfval_valid
  );
endinterface

// File: rtl/cdf_lane_unpack_fifo_beat_fifo.sv
// Generic first-word-fall-through FIFO; head entry is visible on rd_data whenever !empty.
module cdf_beat_fifo #(
  parameter int W     = 256,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [W-1:0]             wr_data,
  output logic [W-1:0]             rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_data = mem[rd_ptr];

  // Storage needs no reset; empty gating downstream hides stale entries.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cdf_lane_unpack_fifo.sv
// Buffers wide CDF read beats and presents them as LANES words to the divider bank.
// Optional macro CDF_MIN_SUB_EN: adds cdf_min input, each lane becomes max(lane - cdf_min, 0).
module cdf_lane_unpack_fifo
  import cdf_pkg::*;
#(
  parameter int WORD_W     = WORD_W_DEF,
  parameter int MEM_W      = MEM_W_DEF,
  parameter int NUM_PORTS  = NUM_PORTS_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          flush,
`ifdef CDF_MIN_SUB_EN
  input  logic [WORD_W-1:0]             cdf_min,
`endif
  cdf_lane_unpack_fifo_if.slave         bus,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);
  localparam int BEAT_W = NUM_PORTS * MEM_W;
  localparam int LANES  = BEAT_W / WORD_W;

  logic                          push, pop, full, empty;
  logic [BEAT_W-1:0]             head;
  logic [LANES-1:0][WORD_W-1:0]  lane;

  // Ready/valid come only from registered count, so no div_ready -> mem_rd_ready path.
  assign push = enable & bus.sc_mem_rd_data_rdy & ~full;
  assign pop  = enable & ~empty & bus.div_ready;

  cdf_beat_fifo #(
    .W     (BEAT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .flush   (flush),
    .wr_data (bus.sc_mem_rd_data),
    .rd_data (head),
    .count   (fifo_count),
    .full    (full),
    .empty   (empty)
  );

  assign bus.mem_rd_ready = ~full;
  assign bus.cdfval_valid = ~empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                       overflow <= 1'b0;
    else if (flush)                                   overflow <= 1'b0;
    else if (enable & bus.sc_mem_rd_data_rdy & full)  overflow <= 1'b1;
  end

  // Lanes are forced to zero while empty so stale storage never leaks out.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
`ifdef CDF_MIN_SUB_EN
    assign lane[k] = empty ? '0 :
      WORD_W'(sat_sub(lane_word(flat_t'(head), k, WORD_W), word_t'(cdf_min)));
`else
    assign lane[k] = empty ? '0 : WORD_W'(lane_word(flat_t'(head), k, WORD_W));
`endif
  end

  assign bus.cdfval_todiv = lane;

endmodule

// File: tb/tb_cdf_lane_unpack_fifo.sv
// Table-driven bench with a queue scoreboard for cdf_lane_unpack_fifo (default parameters).
module tb_cdf_lane_unpack_fifo;
  localparam int WORD_W = 32;
  localparam int LANES  = 8;
  localparam int BEAT_W = 256;
  localparam int DEPTH  = 4;

  typedef logic [BEAT_W-1:0] beat_t;

  typedef struct {
    bit rdy, drdy, en, fl;
    int base;
    int exp_cnt;
    bit exp_ovf;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic enable = 1'b0;
  logic flush = 1'b0;
  logic [WORD_W-1:0] cdf_min_v = '0;
  logic [2:0] fifo_count;
  logic overflow;

  int n_vec = 0;
  int n_mis = 0;
  beat_t sbq[$];
  bit m_ovf = 1'b0;
  vec_t tbl[$];

  cdf_lane_unpack_fifo_if #(.BEAT_W(BEAT_W), .OUT_W(BEAT_W)) bus ();

  cdf_lane_unpack_fifo dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .flush      (flush),
`ifdef CDF_MIN_SUB_EN
    .cdf_min    (cdf_min_v),
`endif
    .bus        (bus.slave),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input beat_t act, input beat_t exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic beat_t mk(input int base);
    beat_t b;
    for (int k = 0; k < LANES; k++) b[k*WORD_W +: WORD_W] = WORD_W'(base + k);
    return b;
  endfunction

  function automatic beat_t exp_of(input beat_t b);
    beat_t r;
    for (int k = 0; k < LANES; k++) begin
      logic [WORD_W-1:0] w;
      w = b[k*WORD_W +: WORD_W];
      r[k*WORD_W +: WORD_W] = (w < cdf_min_v) ? '0 : w - cdf_min_v;
    end
`ifdef CDF_MIN_SUB_EN
    return r;
`else
    return b;
`endif
  endfunction

  // One clock: drive inputs, update scoreboard model, clock, check state.
  task automatic cycle(input bit rdy, input bit drdy, input bit en, input bit fl, input beat_t data);
    bit full_b, m_push, m_pop;
    bus.sc_mem_rd_data_rdy = rdy;
    bus.sc_mem_rd_data     = data;
    bus.div_ready          = drdy;
    enable                 = en;
    flush                  = fl;
    full_b = (sbq.size() == DEPTH);
    m_push = en && rdy && !full_b;
    m_pop  = en && drdy && (sbq.size() > 0);
    if (m_pop && !fl) chk("pop_data", bus.cdfval_todiv, sbq[0]);
    if (fl) begin
      sbq.delete();
      m_ovf = 1'b0;
    end else begin
      if (m_pop) void'(sbq.pop_front());
      if (m_push) sbq.push_back(exp_of(data));
      if (en && rdy && full_b) m_ovf = 1'b1;
    end
    @(posedge clk);
    #1;
    chk("count", beat_t'(fifo_count), beat_t'(sbq.size()));
    chk("valid", beat_t'(bus.cdfval_valid), beat_t'(sbq.size() != 0));
    chk("mem_rd_ready", beat_t'(bus.mem_rd_ready), beat_t'(sbq.size() < DEPTH));
    chk("overflow", beat_t'(overflow), beat_t'(m_ovf));
    if (sbq.size() != 0) chk("head", bus.cdfval_todiv, sbq[0]);
    else                 chk("idle_zero", bus.cdfval_todiv, '0);
  endtask

  task automatic add(input bit rdy, drdy, en, fl, input int base, cnt, input bit ovf);
    vec_t v;
    v.rdy = rdy; v.drdy = drdy; v.en = en; v.fl = fl;
    v.base = base; v.exp_cnt = cnt; v.exp_ovf = ovf;
    tbl.push_back(v);
  endtask

  initial begin
    beat_t b;
    bus.sc_mem_rd_data_rdy = 1'b0;
    bus.sc_mem_rd_data     = '0;
    bus.div_ready          = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", beat_t'(fifo_count), '0);
    chk("rst_valid", beat_t'(bus.cdfval_valid), '0);
    chk("rst_ready", beat_t'(bus.mem_rd_ready), beat_t'(1));
    chk("rst_ovf", beat_t'(overflow), '0);
    chk("rst_data", bus.cdfval_todiv, '0);
    reset = 1'b1;

    // Single beat: lanes 1..8, one-cycle latency, then popped
    cycle(1, 1, 1, 0, mk(1));
    for (int k = 0; k < LANES; k++)
      chk($sformatf("lane%0d", k), beat_t'(bus.cdfval_todiv[k*WORD_W +: WORD_W]),
          exp_of(mk(1)) >> (k*WORD_W) & beat_t'(32'hFFFF_FFFF));
`ifndef CDF_MIN_SUB_EN
    chk("lane7_const", beat_t'(bus.cdfval_todiv[7*WORD_W +: WORD_W]), beat_t'(8));
`endif
    cycle(0, 1, 1, 0, '0);

    // Fill, overflow, drain, flush, enable hold, flush-with-overflow
    add(1,0,1,0, 10, 1,0); add(1,0,1,0, 20, 2,0); add(1,0,1,0, 30, 3,0);
    add(1,0,1,0, 40, 4,0); add(1,0,1,0, 50, 4,1);
    add(0,1,1,0,  0, 3,1); add(0,1,1,0,  0, 2,1); add(0,1,1,0,  0, 1,1);
    add(0,1,1,0,  0, 0,1); add(0,0,1,1,  0, 0,0);
    add(1,0,1,0, 60, 1,0); add(1,0,1,0, 70, 2,0);
    add(1,1,0,0, 99, 2,0); add(1,1,0,0, 99, 2,0); add(1,1,0,0, 99, 2,0);
    add(0,1,1,0,  0, 1,0); add(0,1,1,0,  0, 0,0);
    add(1,0,1,0, 80, 1,0); add(1,0,1,0, 90, 2,0); add(1,0,1,0,100, 3,0);
    add(1,0,1,0,110, 4,0); add(1,0,1,0,120, 4,1); add(0,1,1,0,  0, 3,1);
    add(1,1,1,1,130, 0,0);
    foreach (tbl[i]) begin
      cycle(tbl[i].rdy, tbl[i].drdy, tbl[i].en, tbl[i].fl, mk(tbl[i].base));
      chk($sformatf("tbl%0d_count", i), beat_t'(fifo_count), beat_t'(tbl[i].exp_cnt));
      chk($sformatf("tbl%0d_ovf", i), beat_t'(overflow), beat_t'(tbl[i].exp_ovf));
    end

    // Streaming: push and pop every cycle, pointers wrap several times
    for (int i = 0; i < 16; i++) begin
      cycle(1, 1, 1, 0, mk(i * 16));
      chk("stream_count", beat_t'(fifo_count), beat_t'(1));
    end
    cycle(0, 1, 1, 0, '0);
    chk("stream_ovf", beat_t'(overflow), '0);

    // Reset mid-stream: outputs drop at once, without a clock edge
    cycle(1, 0, 1, 0, mk(200));
    cycle(1, 0, 1, 0, mk(210));
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", beat_t'(bus.cdfval_valid), '0);
    chk("mid_rst_data", bus.cdfval_todiv, '0);
    chk("mid_rst_count", beat_t'(fifo_count), '0);
    chk("mid_rst_ready", beat_t'(bus.mem_rd_ready), beat_t'(1));
    sbq.delete();
    m_ovf = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;

`ifdef CDF_MIN_SUB_EN
    // Saturating subtract of cdf_min
    cdf_min_v = 32'd50;
    b = '0;
    b[0*WORD_W +: WORD_W] = 32'd30;
    b[1*WORD_W +: WORD_W] = 32'd50;
    b[2*WORD_W +: WORD_W] = 32'd51;
    b[3*WORD_W +: WORD_W] = 32'd1000;
    cycle(1, 0, 1, 0, b);
    chk("min_l0", beat_t'(bus.cdfval_todiv[0*WORD_W +: WORD_W]), beat_t'(0));
    chk("min_l1", beat_t'(bus.cdfval_todiv[1*WORD_W +: WORD_W]), beat_t'(0));
    chk("min_l2", beat_t'(bus.cdfval_todiv[2*WORD_W +: WORD_W]), beat_t'(1));
    chk("min_l3", beat_t'(bus.cdfval_todiv[3*WORD_W +: WORD_W]), beat_t'(950));
    cycle(0, 1, 1, 0, '0);
`else
    b = mk(300);
    cycle(1, 0, 1, 0, b);
    chk("pass_l3", beat_t'(bus.cdfval_todiv[3*WORD_W +: WORD_W]), beat_t'(303));
    cycle(0, 1, 1, 0, '0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
